// File: rtl/plab5_mcore_dma_arbiter_pkg.sv
// plab5_mcore_dma_arbiter_pkg: shared FSM encoding, default message widths and the round-robin slot helper.
package plab5_mcore_dma_arbiter_pkg;
  localparam int VC_MEM_REQ_MSG_NBITS = 77;
  localparam int VC_MEM_RESP_MSG_NBITS = 45;
  localparam int MEM_DATA_NBITS = 32;
  localparam int REQ_CNBITS = VC_MEM_REQ_MSG_NBITS - MEM_DATA_NBITS;
  localparam int RESP_CNBITS = VC_MEM_RESP_MSG_NBITS - MEM_DATA_NBITS;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  function automatic int rr_slot(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction
endpackage

// File: rtl/plab5_mcore_dma_arbiter_rr_arb.sv
// plab5_mcore_dma_arbiter_rr_arb: combinational round-robin pick of the first request at or after ptr.
module plab5_mcore_dma_arbiter_rr_arb
  import plab5_mcore_dma_arbiter_pkg::*;
#(
  parameter int p_num_reqs = 2
) (
  input  logic [p_num_reqs-1:0]         reqs,
  input  logic [$clog2(p_num_reqs)-1:0] ptr,
  output logic [p_num_reqs-1:0]         grant,
  output logic [$clog2(p_num_reqs)-1:0] idx,
  output logic                          any
);
  localparam int IW = $clog2(p_num_reqs);
  logic [IW-1:0] slot;
  // scanning from the far end lets the closest slot to ptr overwrite the rest
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    slot = '0;
    for (int k = p_num_reqs - 1; k >= 0; k--) begin
      slot = IW'(rr_slot(int'(ptr), k, p_num_reqs));
      if (reqs[slot]) begin
        grant = p_num_reqs'(1) << slot;
        idx = slot;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/plab5_mcore_dma_arbiter.sv
// plab5_mcore_dma_arbiter: shares one DMA controller among requesters, one command at a time,
// with round-robin grant, watchdog on completion and response routed back to the grantee.
module plab5_mcore_dma_arbiter
  import plab5_mcore_dma_arbiter_pkg::*;
#(
  parameter int p_num_reqs    = 2,
  parameter int p_addr_nbits  = 32,
  parameter int p_req_cnbits  = REQ_CNBITS,
  parameter int p_resp_cnbits = RESP_CNBITS,
  parameter int p_timeout     = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [p_num_reqs-1:0]              req_val,
  output logic [p_num_reqs-1:0]              req_rdy,
  input  logic [p_num_reqs-1:0]              req_domain,
  input  logic [p_num_reqs*p_addr_nbits-1:0] req_src_addr,
  input  logic [p_num_reqs*p_addr_nbits-1:0] req_dest_addr,
  input  logic [p_num_reqs*p_req_cnbits-1:0] req_control,
  output logic [p_num_reqs-1:0]              resp_val,
  output logic [p_resp_cnbits-1:0]           resp_control,
  output logic                               resp_domain,
  output logic                               resp_err,
  output logic                               dma_val,
  input  logic                               dma_rdy,
  output logic                               dma_domain,
  output logic [p_addr_nbits-1:0]            dma_src_addr,
  output logic [p_addr_nbits-1:0]            dma_dest_addr,
  output logic [p_req_cnbits-1:0]            dma_req_control,
  input  logic                               dma_ack,
  input  logic [p_resp_cnbits-1:0]           dma_resp_control
);
  localparam int IW = $clog2(p_num_reqs);
  localparam int CW = $clog2(p_timeout);
  localparam logic [CW-1:0] last = CW'(p_timeout - 1);
  state_e state;
  logic [IW-1:0] ptr, grant, win_idx;
  logic [p_num_reqs-1:0] win;
  logic win_any, domain, err, expired;
  logic [CW-1:0] count;
  logic [p_addr_nbits-1:0] src, dest;
  logic [p_req_cnbits-1:0] ctrl;
  logic [p_resp_cnbits-1:0] rctrl;
  plab5_mcore_dma_arbiter_rr_arb #(.p_num_reqs(p_num_reqs)) rr_arb (
    .reqs(req_val), .ptr(ptr), .grant(win), .idx(win_idx), .any(win_any)
  );
  assign req_rdy = (state == IDLE) ? win : '0;
  assign dma_val = state == ISSUE;
  assign dma_domain = dma_val & domain;
  assign dma_src_addr = dma_val ? src : '0;
  assign dma_dest_addr = dma_val ? dest : '0;
  assign dma_req_control = dma_val ? ctrl : '0;
  assign resp_val = (state == RESP) ? p_num_reqs'(1) << grant : '0;
  assign resp_control = (state == RESP) ? rctrl : '0;
  assign resp_domain = (state == RESP) & domain;
  assign resp_err = (state == RESP) & err;
  // expired trails the saturated count by a cycle, so timeout lands p_timeout+1 cycles into WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      count <= '0;
      expired <= 1'b0;
      domain <= 1'b0;
      src <= '0;
      dest <= '0;
      ctrl <= '0;
      rctrl <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_any) begin
          state <= ISSUE;
          grant <= win_idx;
          domain <= req_domain[win_idx];
          src <= req_src_addr[win_idx*p_addr_nbits +: p_addr_nbits];
          dest <= req_dest_addr[win_idx*p_addr_nbits +: p_addr_nbits];
          ctrl <= req_control[win_idx*p_req_cnbits +: p_req_cnbits];
        end
        ISSUE: if (dma_rdy) begin
          state <= WAIT;
          count <= '0;
          expired <= 1'b0;
        end
        WAIT: begin
          count <= (count == last) ? count : count + 1'b1;
          expired <= count == last;
          if (dma_ack || expired) begin
            state <= RESP;
            rctrl <= dma_ack ? dma_resp_control : '0;
            err <= !dma_ack;
          end
        end
        RESP: begin
          state <= IDLE;
          ptr <= (grant == IW'(p_num_reqs - 1)) ? '0 : grant + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_plab5_mcore_dma_arbiter.sv
// tb_plab5_mcore_dma_arbiter: directed transaction table plus randomized traffic against a
// transaction-level round-robin/watchdog model.
module tb_plab5_mcore_dma_arbiter;
  localparam int N = 3, A = 16, C = 12, R = 8, TO = 8;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req_val, req_rdy, req_domain, resp_val;
  logic [N*A-1:0] req_src_addr, req_dest_addr;
  logic [N*C-1:0] req_control;
  logic [R-1:0] resp_control, dma_resp_control;
  logic resp_domain, resp_err, dma_val, dma_rdy, dma_domain, dma_ack;
  logic [A-1:0] dma_src_addr, dma_dest_addr;
  logic [C-1:0] dma_req_control;
  logic [127:0] outs;
  int compared = 0, mismatched = 0;
  logic [N-1:0] pend, dom;
  logic [A-1:0] src[N], dst[N];
  logic [C-1:0] ctl[N];
  int ptr_m = 0;
  typedef struct {
    logic [N-1:0] pend;
    logic [N-1:0] dom;
    int win, rdy, ack, rst, late;
  } vec_t;
  vec_t tv[18];
  plab5_mcore_dma_arbiter #(
    .p_num_reqs(N), .p_addr_nbits(A), .p_req_cnbits(C), .p_resp_cnbits(R), .p_timeout(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_domain(req_domain),
    .req_src_addr(req_src_addr), .req_dest_addr(req_dest_addr), .req_control(req_control),
    .resp_val(resp_val), .resp_control(resp_control), .resp_domain(resp_domain), .resp_err(resp_err),
    .dma_val(dma_val), .dma_rdy(dma_rdy), .dma_domain(dma_domain), .dma_src_addr(dma_src_addr),
    .dma_dest_addr(dma_dest_addr), .dma_req_control(dma_req_control), .dma_ack(dma_ack),
    .dma_resp_control(dma_resp_control)
  );
  always #5 clk = ~clk;
  assign outs = 128'({req_rdy, resp_val, resp_control, resp_domain, resp_err, dma_val, dma_domain,
                      dma_src_addr, dma_dest_addr, dma_req_control});
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic en);
    for (int i = 0; i < N; i++) begin
      req_src_addr[i*A +: A] = src[i];
      req_dest_addr[i*A +: A] = dst[i];
      req_control[i*C +: C] = ctl[i];
    end
    req_val = en ? pend : '0;
    req_domain = dom;
  endtask
  task automatic new_cmd(input int i);
    dom[i] = 1'($urandom);
    src[i] = A'($urandom);
    dst[i] = A'($urandom);
    ctl[i] = C'($urandom);
  endtask
  // one complete transaction; ack_at is the WAIT cycle index of the ack (-1 = never)
  task automatic txn(input int w, input int rdy_wait, input int ack_at, input int rst_at, input int late);
    logic [R-1:0] rc;
    logic err;
    int last;
    rc = R'($urandom);
    err = !(ack_at >= 0 && ack_at <= TO);
    last = err ? TO : ack_at;
    @(negedge clk);
    dma_rdy = 1'b0;
    dma_ack = 1'b0;
    drive(1'b1);
    #1;
    chk("grant", 128'(req_rdy), 128'(N'(1) << w));
    pend[w] = 1'b0;
    for (int k = 0; k <= rdy_wait; k++) begin
      @(negedge clk);
      drive(1'b1);
      dma_rdy = (k == rdy_wait);
      #1;
      chk("issue", 128'({req_rdy, dma_val, dma_domain, dma_src_addr, dma_dest_addr, dma_req_control}),
          128'({N'(0), 1'b1, dom[w], src[w], dst[w], ctl[w]}));
    end
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      dma_rdy = 1'b0;
      dma_ack = (k == ack_at);
      dma_resp_control = (k == ack_at) ? rc : R'($urandom);
      #1;
      chk("wait", 128'({dma_val, dma_src_addr, resp_val, resp_control, resp_err}), 128'(0));
      if (k == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        dma_ack = 1'b0;
        drive(1'b0);
        #1;
        chk("reset_outs", outs, 128'(0));
        @(negedge clk);
        dma_ack = 1'b1;
        dma_resp_control = '1;
        @(negedge clk);
        dma_ack = 1'b0;
        #1;
        chk("ack_after_reset", outs, 128'(0));
        ptr_m = 0;
        return;
      end
    end
    @(negedge clk);
    dma_ack = 1'b0;
    #1;
    chk("resp", 128'({resp_val, resp_control, resp_domain, resp_err, dma_val}),
        128'({N'(1) << w, err ? R'(0) : rc, dom[w], err, 1'b0}));
    ptr_m = (w + 1) % N;
    if (late != 0) begin
      @(negedge clk);
      drive(1'b0);
      @(negedge clk);
      dma_ack = 1'b1;
      dma_resp_control = '1;
      @(negedge clk);
      dma_ack = 1'b0;
      #1;
      chk("late_ack", outs, 128'(0));
    end
  endtask
  initial begin
    int w;
    tv[0]  = '{3'b001, 3'b001, 0, 0, 2, -1, 0};
    tv[1]  = '{3'b011, 3'b000, 1, 0, 0, -1, 0};
    tv[2]  = '{3'b011, 3'b010, 0, 0, 1, -1, 0};
    tv[3]  = '{3'b011, 3'b001, 1, 1, 0, -1, 0};
    tv[4]  = '{3'b011, 3'b011, 0, 0, 3, -1, 0};
    tv[5]  = '{3'b011, 3'b010, 1, 0, 0, -1, 0};
    tv[6]  = '{3'b001, 3'b000, 0, 0, 0, -1, 0};
    tv[7]  = '{3'b011, 3'b001, 1, 0, 0, -1, 0};
    tv[8]  = '{3'b100, 3'b100, 2, 0, -1, -1, 1};
    tv[9]  = '{3'b001, 3'b000, 0, 0, 0, -1, 0};
    tv[10] = '{3'b010, 3'b010, 1, 0, TO, -1, 0};
    tv[11] = '{3'b100, 3'b000, 2, 5, 1, -1, 0};
    tv[12] = '{3'b111, 3'b101, 0, 0, 0, -1, 0};
    tv[13] = '{3'b101, 3'b000, 2, 0, 0, -1, 0};
    tv[14] = '{3'b110, 3'b000, 1, 0, 0, -1, 0};
    tv[15] = '{3'b011, 3'b000, 0, 0, 0, -1, 0};
    tv[16] = '{3'b010, 3'b010, 1, 0, 5, 3, 0};
    tv[17] = '{3'b011, 3'b000, 0, 0, 0, -1, 0};
    reset = 1'b1;
    dma_rdy = 1'b0;
    dma_ack = 1'b0;
    dma_resp_control = '0;
    pend = '0;
    dom = '0;
    for (int i = 0; i < N; i++) begin
      src[i] = '0;
      dst[i] = '0;
      ctl[i] = '0;
    end
    drive(1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state", outs, 128'(0));
    for (int e = 0; e < 18; e++) begin
      for (int i = 0; i < N; i++) new_cmd(i);
      if (e == 0) begin
        src[0] = A'(16'h0100);
        dst[0] = A'(16'h0200);
      end
      pend = tv[e].pend;
      dom = tv[e].dom;
      txn(tv[e].win, tv[e].rdy, tv[e].ack, tv[e].rst, tv[e].late);
    end
    pend = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          new_cmd(i);
        end
      if (pend == '0) begin
        w = $urandom_range(0, N - 1);
        pend[w] = 1'b1;
        new_cmd(w);
      end
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && pend[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      txn(w, $urandom_range(0, 3), ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TO + 2), -1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
